// File: rtl/noc_injection_arbiter.sv
// Packet-atomic round-robin injection arbiter for one NoC router input port.
// It holds a per-packet lock and tracks downstream credits, and its output stage is registered.
module noc_injection_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int FLIT_WIDTH        = 256,
  parameter int DEST_WIDTH        = 3,
  parameter int FLIT_BUFFER_DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ*FLIT_WIDTH-1:0]        req_data,
  input  logic [NUM_REQ*DEST_WIDTH-1:0]        req_dest,
  input  logic [NUM_REQ-1:0]                   req_is_tail,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [FLIT_WIDTH-1:0]                data_out,
  output logic [DEST_WIDTH-1:0]                dest_out,
  output logic                                 is_tail_out,
  output logic                                 send_out,
  input  logic                                 credit_in,
  output logic [$clog2(FLIT_BUFFER_DEPTH):0]   credit_count,
  output logic                                 locked,
  output logic [$clog2(NUM_REQ)-1:0]           owner,
  output logic                                 credit_err
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FLIT_BUFFER_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FLIT_BUFFER_DEPTH);
  localparam logic [OW-1:0] LAST_C  = OW'(NUM_REQ - 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                 state_q, state_d;
  logic [OW-1:0]          owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]          credit_q, credit_d;
  logic                   credit_err_q, credit_err_d;
  logic                   send_q, send_d, tail_q, tail_d;
  logic [FLIT_WIDTH-1:0]  data_q, data_d;
  logic [DEST_WIDTH-1:0]  dest_q, dest_d;

  logic [OW-1:0]          winner, grant_idx;
  logic                   found, grant_en, fire, fire_tail;
  logic [FLIT_WIDTH-1:0]  data_arr [NUM_REQ];
  logic [DEST_WIDTH-1:0]  dest_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*FLIT_WIDTH +: FLIT_WIDTH];
    assign dest_arr[gi] = req_dest[gi*DEST_WIDTH +: DEST_WIDTH];
  end

  function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  // Rotating priority search starting at rr_ptr_q.
  always_comb begin
    int            idx;
    logic [OW-1:0] idx_t;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    idx_t  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_t = OW'(idx);
      if (!found && req_valid[idx_t]) begin
        found  = 1'b1;
        winner = idx_t;
      end
    end
  end

  // While locked the owner keeps the grant even with valid low, so bubbles never reopen arbitration.
  always_comb begin
    grant_idx = (state_q == LOCKED) ? owner_q : winner;
    grant_en  = ((state_q == LOCKED) || found) && (credit_q != '0);
    req_ready = '0;
    if (grant_en) req_ready[grant_idx] = 1'b1;
    fire      = grant_en && req_valid[grant_idx];
    fire_tail = req_is_tail[grant_idx];
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    send_d       = fire;
    data_d       = data_q;
    tail_d       = 1'b0;
    dest_d       = dest_q;
    credit_d     = credit_q;
    credit_err_d = credit_err_q;

    if (fire) begin
      data_d = data_arr[grant_idx];
      tail_d = fire_tail;
    end

    case (state_q)
      IDLE: begin
        if (fire) begin
          owner_d = winner;
          dest_d  = dest_arr[winner];
          if (fire_tail) rr_ptr_d = next_idx(winner);
          else           state_d  = LOCKED;
        end
      end
      LOCKED: begin
        if (fire && fire_tail) begin
          state_d  = IDLE;
          rr_ptr_d = next_idx(owner_q);
        end
      end
      default: state_d = IDLE;
    endcase

    // A returned credit with a full count indicates a protocol error upstream.
    if (credit_in && !fire) begin
      if (credit_q == DEPTH_C) credit_err_d = 1'b1;
      else                     credit_d     = credit_q + 1'b1;
    end else if (!credit_in && fire) begin
      credit_d = credit_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      credit_q     <= DEPTH_C;
      credit_err_q <= 1'b0;
      send_q       <= 1'b0;
      tail_q       <= 1'b0;
      data_q       <= '0;
      dest_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      credit_q     <= credit_d;
      credit_err_q <= credit_err_d;
      send_q       <= send_d;
      tail_q       <= tail_d;
      data_q       <= data_d;
      dest_q       <= dest_d;
    end
  end

  assign data_out     = data_q;
  assign dest_out     = dest_q;
  assign is_tail_out  = tail_q;
  assign send_out     = send_q;
  assign credit_count = credit_q;
  assign locked       = (state_q == LOCKED);
  assign owner        = owner_q;
  assign credit_err   = credit_err_q;

endmodule

// File: tb/tb_noc_injection_arbiter.sv
// Directed table-driven bench for noc_injection_arbiter (4 requesters, depth-2 credits).
module tb_noc_injection_arbiter;

  localparam int NR = 4;
  localparam int FW = 256;
  localparam int DW = 3;
  localparam int FD = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NR*FW-1:0]    req_data;
  logic [NR*DW-1:0]    req_dest;
  logic [NR-1:0]       req_is_tail;
  logic [NR-1:0]       req_valid;
  logic [NR-1:0]       req_ready;
  logic [FW-1:0]       data_out;
  logic [DW-1:0]       dest_out;
  logic                is_tail_out;
  logic                send_out;
  logic                credit_in;
  logic [1:0]          credit_count;
  logic                locked;
  logic [1:0]          owner;
  logic                credit_err;

  int n_checks = 0;
  int n_pass   = 0;

  noc_injection_arbiter #(
    .NUM_REQ(NR), .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst),
    .req_data(req_data), .req_dest(req_dest), .req_is_tail(req_is_tail),
    .req_valid(req_valid), .req_ready(req_ready),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
    .send_out(send_out), .credit_in(credit_in), .credit_count(credit_count),
    .locked(locked), .owner(owner), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] tail;
    logic [2:0] dest;
    logic       cin;
    logic [3:0] ready;
    logic       send;
    logic       etail;
    logic [2:0] edest;
    logic       lock;
    logic [1:0] own;
    logic [1:0] cred;
  } vec_t;

  vec_t tbl [17];

  function automatic logic [FW-1:0] data_val(input int r, input int i);
    logic [7:0] rb, ib;
    rb = 8'(r);
    ib = 8'(i);
    return {16'hC0DE, 224'd0, rb, ib};
  endfunction

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Requester i carries data_val(row,i) and destination dest_base+i.
  task automatic drive(input logic [3:0] v, input logic [3:0] t, input logic [2:0] dest_base,
                       input logic cin, input int row);
    for (int i = 0; i < NR; i++) begin
      req_data[i*FW +: FW] = data_val(row, i);
      req_dest[i*DW +: DW] = dest_base + 3'(i);
    end
    req_valid   = v;
    req_is_tail = t;
    credit_in   = cin;
  endtask

  initial begin
    int idx;
    // valid tail dest cin | ready send etail edest lock own cred
    tbl[0]  = '{4'b0001, 4'b0000, 3'd5, 1'b1, 4'b0001, 1'b1, 1'b0, 3'd5, 1'b1, 2'd0, 2'd2};
    tbl[1]  = '{4'b0001, 4'b0000, 3'd1, 1'b1, 4'b0001, 1'b1, 1'b0, 3'd5, 1'b1, 2'd0, 2'd2};
    tbl[2]  = '{4'b0001, 4'b0001, 3'd1, 1'b1, 4'b0001, 1'b1, 1'b1, 3'd5, 1'b0, 2'd0, 2'd2};
    tbl[3]  = '{4'b0000, 4'b0000, 3'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd5, 1'b0, 2'd0, 2'd2};
    tbl[4]  = '{4'b1111, 4'b1111, 3'd2, 1'b1, 4'b0010, 1'b1, 1'b1, 3'd3, 1'b0, 2'd1, 2'd2};
    tbl[5]  = '{4'b1111, 4'b1111, 3'd2, 1'b1, 4'b0100, 1'b1, 1'b1, 3'd4, 1'b0, 2'd2, 2'd2};
    tbl[6]  = '{4'b1111, 4'b1111, 3'd2, 1'b1, 4'b1000, 1'b1, 1'b1, 3'd5, 1'b0, 2'd3, 2'd2};
    tbl[7]  = '{4'b1111, 4'b1111, 3'd2, 1'b1, 4'b0001, 1'b1, 1'b1, 3'd2, 1'b0, 2'd0, 2'd2};
    tbl[8]  = '{4'b1111, 4'b1111, 3'd2, 1'b1, 4'b0010, 1'b1, 1'b1, 3'd3, 1'b0, 2'd1, 2'd2};
    tbl[9]  = '{4'b0010, 4'b0000, 3'd6, 1'b1, 4'b0010, 1'b1, 1'b0, 3'd7, 1'b1, 2'd1, 2'd2};
    tbl[10] = '{4'b0110, 4'b0000, 3'd0, 1'b1, 4'b0010, 1'b1, 1'b0, 3'd7, 1'b1, 2'd1, 2'd2};
    tbl[11] = '{4'b0100, 4'b0000, 3'd0, 1'b0, 4'b0010, 1'b0, 1'b0, 3'd7, 1'b1, 2'd1, 2'd2};
    tbl[12] = '{4'b0100, 4'b0000, 3'd0, 1'b0, 4'b0010, 1'b0, 1'b0, 3'd7, 1'b1, 2'd1, 2'd2};
    tbl[13] = '{4'b0110, 4'b0000, 3'd0, 1'b1, 4'b0010, 1'b1, 1'b0, 3'd7, 1'b1, 2'd1, 2'd2};
    tbl[14] = '{4'b0110, 4'b0010, 3'd0, 1'b1, 4'b0010, 1'b1, 1'b1, 3'd7, 1'b0, 2'd1, 2'd2};
    tbl[15] = '{4'b0100, 4'b0100, 3'd3, 1'b1, 4'b0100, 1'b1, 1'b1, 3'd5, 1'b0, 2'd2, 2'd2};
    tbl[16] = '{4'b0000, 4'b0000, 3'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd5, 1'b0, 2'd2, 2'd2};

    rst = 1'b1;
    drive(4'b0000, 4'b0000, 3'd0, 1'b0, 0);
    step();
    step();
    chk("rst_send",   send_out,     0);
    chk("rst_data",   data_out,     0);
    chk("rst_dest",   dest_out,     0);
    chk("rst_tail",   is_tail_out,  0);
    chk("rst_credit", credit_count, 2);
    chk("rst_locked", locked,       0);
    chk("rst_owner",  owner,        0);
    chk("rst_err",    credit_err,   0);
    rst = 1'b0;

    for (int r = 0; r < 17; r++) begin
      drive(tbl[r].valid, tbl[r].tail, tbl[r].dest, tbl[r].cin, r);
      #1;
      chk($sformatf("row%0d_ready", r), req_ready, tbl[r].ready);
      step();
      chk($sformatf("row%0d_send", r),   send_out,     tbl[r].send);
      chk($sformatf("row%0d_tail", r),   is_tail_out,  tbl[r].etail);
      chk($sformatf("row%0d_locked", r), locked,       tbl[r].lock);
      chk($sformatf("row%0d_owner", r),  owner,        tbl[r].own);
      chk($sformatf("row%0d_credit", r), credit_count, tbl[r].cred);
      chk($sformatf("row%0d_err", r),    credit_err,   0);
      if (tbl[r].send) begin
        idx = 0;
        for (int i = 0; i < NR; i++)
          if (tbl[r].ready[i] && tbl[r].valid[i]) idx = i;
        chk($sformatf("row%0d_dest", r), dest_out, tbl[r].edest);
        chk($sformatf("row%0d_data", r), data_out, data_val(r, idx));
      end
      $display("row %0d: valid=%b ready=%b send=%0d owner=%0d credit=%0d",
               r, tbl[r].valid, req_ready, send_out, owner, credit_count);
    end

    // Credit exhaustion with no returns: two flits then a stall.
    drive(4'b0001, 4'b0000, 3'd5, 1'b0, 200); #1;
    chk("crA_ready", req_ready, 4'b0001);
    step();
    chk("crA_credit", credit_count, 1);
    chk("crA_send", send_out, 1);
    drive(4'b0001, 4'b0000, 3'd5, 1'b0, 201); #1;
    chk("crB_ready", req_ready, 4'b0001);
    step();
    chk("crB_credit", credit_count, 0);
    drive(4'b0001, 4'b0000, 3'd5, 1'b0, 202); #1;
    chk("crC_ready", req_ready, 4'b0000);
    step();
    chk("crC_send", send_out, 0);
    drive(4'b0001, 4'b0000, 3'd5, 1'b1, 203); #1;
    chk("crD_ready_same_cycle", req_ready, 4'b0000);
    step();
    chk("crD_credit", credit_count, 1);
    chk("crD_send", send_out, 0);
    drive(4'b0001, 4'b0000, 3'd5, 1'b0, 204); #1;
    chk("crE_ready", req_ready, 4'b0001);
    step();
    chk("crE_send", send_out, 1);
    chk("crE_data", data_out, data_val(204, 0));
    chk("crE_credit", credit_count, 0);
    $display("credit stall sequence done, credit=%0d", credit_count);

    // Simultaneous credit return and fire at count 1.
    drive(4'b0001, 4'b0000, 3'd5, 1'b1, 205); #1;
    step();
    chk("crF_credit", credit_count, 1);
    drive(4'b0001, 4'b0000, 3'd5, 1'b1, 206); #1;
    chk("crG_ready", req_ready, 4'b0001);
    step();
    chk("crG_credit", credit_count, 1);
    chk("crG_err", credit_err, 0);
    chk("crG_send", send_out, 1);
    drive(4'b0001, 4'b0001, 3'd5, 1'b1, 207); #1;
    step();
    chk("crH_credit", credit_count, 1);
    chk("crH_tail", is_tail_out, 1);
    chk("crH_locked", locked, 0);
    $display("simultaneous credit/fire done, credit=%0d", credit_count);

    // Overflow: return credits with the counter already full.
    drive(4'b0000, 4'b0000, 3'd0, 1'b1, 208);
    step();
    chk("ovI_credit", credit_count, 2);
    chk("ovI_err", credit_err, 0);
    step();
    chk("ovJ_credit", credit_count, 2);
    chk("ovJ_err", credit_err, 1);
    $display("overflow done, err=%0d", credit_err);

    // Asynchronous reset in the middle of a packet.
    drive(4'b0001, 4'b0000, 3'd4, 1'b0, 209); #1;
    step();
    chk("rsK_send", send_out, 1);
    chk("rsK_locked", locked, 1);
    chk("rsK_credit", credit_count, 1);
    #2 rst = 1'b1;
    #1;
    chk("rsK_async_send", send_out, 0);
    chk("rsK_async_locked", locked, 0);
    chk("rsK_async_credit", credit_count, 2);
    chk("rsK_async_err", credit_err, 0);
    step();
    rst = 1'b0;
    drive(4'b0000, 4'b0000, 3'd0, 1'b0, 210);
    step();
    chk("rsL_send", send_out, 0);
    chk("rsL_locked", locked, 0);
    $display("mid-packet reset done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/noc_injection_arbiter.md
Name: noc_injection_arbiter

Overview:
- Shares one router input port among NUM_REQ local requesters (traffic sources on one endpoint).
- Packet-atomic round-robin: once a head flit wins, the port is locked to that requester until its tail flit is sent.
- Tracks downstream flit-buffer credits, so it never issues a flit without a free slot.
- Output is registered and drives the router's data_in/dest_in/is_tail_in/send_in; credit_in is fed from the router's credit_out.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- FLIT_WIDTH, 256, flit payload width.
- DEST_WIDTH, 3, destination field width.
- FLIT_BUFFER_DEPTH, 2, downstream flit buffer depth; initial credit count.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_data  in  FLIT_WIDTH x NUM_REQ  per-requester flit payload.
- req_dest  in  DEST_WIDTH x NUM_REQ  per-requester destination; sampled only on head flits.
- req_is_tail  in  NUM_REQ  per-requester tail marker.
- req_valid  in  NUM_REQ  requester has a flit.
- req_ready  out  NUM_REQ  flit accepted this cycle when valid&ready.
- data_out  out  FLIT_WIDTH  flit to router.
- dest_out  out  DEST_WIDTH  destination to router.
- is_tail_out  out  1  tail marker to router.
- send_out  out  1  flit valid to router (one-cycle pulse per flit).
- credit_in  in  1  one credit returned by router.
- credit_count  out  $clog2(FLIT_BUFFER_DEPTH)+1  current credits (debug).
- locked  out  1  packet in progress.
- owner  out  $clog2(NUM_REQ)  current or last winner.
- credit_err  out  1  sticky credit-overflow flag.

Behaviour:
- Reset (async assert, sync deassert use):
  - send_out=0, data_out/dest_out/is_tail_out=0.
  - credit_count=FLIT_BUFFER_DEPTH, locked=0, owner=0, rr_ptr=0, credit_err=0.
- States:
  - IDLE (locked=0): arbitration open.
  - LOCKED (locked=1): only the owner can be granted.
- IDLE grant:
  - Winner = first requester with req_valid set, searching from rr_ptr upward with wrap.
  - req_ready[winner]=1 only if credit_count>0; every other req_ready=0.
- LOCKED grant: req_ready[owner]=1 iff credit_count>0; all others 0, even when the owner's valid is low (bubbles allowed, lock held).
- req_ready is combinational from req_valid, state and credit_count. It has no dependence on credit_in in the same cycle.
- Accept (fire = valid&ready on the granted index):
  - Next cycle: send_out=1 and data_out/is_tail_out = that flit.
  - dest_out = the req_dest of the packet's head flit, repeated for body/tail flits.
  - Latency is exactly 1 cycle; with no fire, next-cycle send_out=0.
- State transitions:
  - IDLE, head fire, not tail: go to LOCKED; owner=winner.
  - IDLE, fire on a single-flit packet (tail=1): stay IDLE; owner=winner; rr_ptr=winner+1 mod NUM_REQ.
  - LOCKED, tail fire: go to IDLE; rr_ptr=owner+1 mod NUM_REQ.
  - LOCKED, non-tail fire or no fire: stay LOCKED.
- Credits:
  - next credit_count = credit_count + credit_in − fire.
  - Simultaneous credit_in and fire leaves the count unchanged.
  - Count never goes below 0, because fire requires credit_count>0.
  - credit_in when credit_count==FLIT_BUFFER_DEPTH and no fire: count saturates at DEPTH and credit_err sets. credit_err clears only on rst.
- Fairness: with all requesters continuously valid and unlimited credits, packets are granted in order rr_ptr, rr_ptr+1, …, with no starvation.
- Reset mid-packet: lock is dropped immediately and no further flits are sent. The NoC is reset as a whole, so the partial packet downstream is cleared by the router's own reset.
- Back-to-back packets: the IDLE decision in the cycle after a tail fire uses the updated rr_ptr. No idle cycle is inserted between packets when credits allow.

Test Plan:
- Reset, then req_valid=4'b0001 with a 3-flit packet, dest=5, credit_in returned every cycle → send_out high 3 consecutive cycles starting 1 cycle after the first fire; dest_out=5 on all three; is_tail_out only on the 3rd; locked falls after the tail.
- All 4 requesters valid with single-flit packets, credits unlimited → grant order 0,1,2,3,0,…; owner increments each cycle; rr_ptr wraps.
- Requester 1 sends a 4-flit packet while requester 2 is valid and requester 1 drops valid for 2 cycles mid-packet → req_ready[2] stays 0 throughout; locked=1; req_ready[1]=1 during the bubble; requester 2 is granted the cycle after requester 1's tail fires.
- FLIT_BUFFER_DEPTH=2, no credit_in → exactly 2 flits fire, credit_count reaches 0 and req_ready goes all-zero. One credit_in pulse → exactly one more flit fires 1 cycle later.
- Same cycle credit_in=1 and fire with credit_count=1 → credit_count stays 1; credit_err stays 0.
- credit_in pulse at credit_count=2 (DEPTH=2), no traffic → credit_count stays 2 and credit_err=1. Assert rst mid-packet → send_out=0, locked=0, credit_count=2 and credit_err=0 immediately, without waiting for a clock edge.
